// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Multi-cycle sequencer for register-specified shifts in the EX stage. The
// shift amount comes from Rs[7:0], so it can be anywhere in 0..255. The
// operand is shifted iteratively, up to STEP bits per cycle, and the shifted
// value and shifter carry-out follow ARM semantics. While the sequencer works
// it raises o_busy so that the hazard unit stalls the pipeline.
//
// Parameters:
//   STEP    bits shifted per SHIFT cycle (1, 2, 4 or 8)
//   DATA_W  operand width (only 32 is supported)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       shift request, sampled only while o_ready is high
//   i_shift_type  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   i_value       Rm operand
//   i_amount      Rs[7:0] shift amount
//   i_carry_in    current C flag
//   i_flush       synchronous abort, returns to IDLE at the next edge
//   o_ready       high only in IDLE
//   o_busy        inverse of o_ready, stall request to the hazard unit
//   o_done        one-cycle pulse, o_val_out/o_carry_out valid in that cycle
//   o_val_out     registered shifted result, held until the next DONE
//   o_carry_out   registered shifter carry, held until the next DONE
//
// Optional build macro:
//   SHIFT_SEQ_EARLY_OUT_EN  when defined, LSL/LSR/ASR with an effective count
//                           of 32 or more finish after a single SHIFT cycle by
//                           loading the saturated result directly. ROR and
//                           shorter counts still run iteratively.
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int STEP   = 4,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_shift_type,
    input  logic [DATA_W-1:0] i_value,
    input  logic [7:0]        i_amount,
    input  logic              i_carry_in,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_val_out,
    output logic              o_carry_out
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [5:0] STEP_CNT = 6'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [DATA_W-1:0]   r_work;
    logic                r_carry;
    logic [5:0]          r_count;
    logic [1:0]          r_type;
    logic [DATA_W-1:0]   r_valOut;
    logic                r_carryOut;

    logic                w_accept;
    logic [5:0]          w_effCount;
    logic [DATA_W-1:0]   w_stepWork;
    logic                w_stepCarry;
    logic [5:0]          w_stepN;
    logic [5:0]          w_remainAfter;
    logic [DATA_W-1:0]   w_shiftWork;
    logic                w_shiftCarry;
    logic                w_shiftDone;

    // A request is taken only from IDLE, and a simultaneous flush drops it.
    assign w_accept = (r_state == ST_IDLE) && i_start && !i_flush;

    // Effective shift count. Anything beyond 33 for the logical shifts gives
    // the same result as 33 (zero result, zero carry), and anything beyond 32
    // for ASR is the same as 32 (sign fill). ROR only cares about the low five
    // bits, except that a nonzero multiple of 32 must still produce the
    // "carry = bit 31" behaviour, so it is mapped to a full 32-bit rotation.
    always_comb begin
        w_effCount = 6'd0;
        case (i_shift_type)
            SH_LSL, SH_LSR: begin
                w_effCount = (i_amount > 8'd33) ? 6'd33 : i_amount[5:0];
            end
            SH_ASR: begin
                w_effCount = (i_amount > 8'd32) ? 6'd32 : i_amount[5:0];
            end
            default: begin
                if (i_amount == 8'd0) begin
                    w_effCount = 6'd0;
                end else if (i_amount[4:0] == 5'd0) begin
                    w_effCount = 6'd32;
                end else begin
                    w_effCount = {1'b0, i_amount[4:0]};
                end
            end
        endcase
    end

    // One SHIFT cycle: apply up to STEP single-bit shifts, stopping once the
    // remaining count is used up. The carry register always ends up holding
    // the last bit that left the word. ASR refills from the current top bit,
    // which never changes, so it is the original sign bit throughout.
    always_comb begin
        w_stepWork  = r_work;
        w_stepCarry = r_carry;
        for (int i = 0; i < STEP; i++) begin
            if (6'(i) < r_count) begin
                case (r_type)
                    SH_LSL: begin
                        w_stepCarry = w_stepWork[DATA_W-1];
                        w_stepWork  = {w_stepWork[DATA_W-2:0], 1'b0};
                    end
                    SH_LSR: begin
                        w_stepCarry = w_stepWork[0];
                        w_stepWork  = {1'b0, w_stepWork[DATA_W-1:1]};
                    end
                    SH_ASR: begin
                        w_stepCarry = w_stepWork[0];
                        w_stepWork  = {w_stepWork[DATA_W-1], w_stepWork[DATA_W-1:1]};
                    end
                    default: begin
                        w_stepCarry = w_stepWork[0];
                        w_stepWork  = {w_stepWork[0], w_stepWork[DATA_W-1:1]};
                    end
                endcase
            end
        end
    end

    // Bits consumed this cycle and what is left afterwards.
    always_comb begin
        w_stepN       = (r_count > STEP_CNT) ? STEP_CNT : r_count;
        w_remainAfter = r_count - w_stepN;
    end

`ifdef SHIFT_SEQ_EARLY_OUT_EN
    logic                w_earlyOut;
    logic [DATA_W-1:0]   w_earlyWork;
    logic                w_earlyCarry;

    // Saturated results for long non-rotating shifts. A count of 32 or more
    // can only be seen in the first SHIFT cycle, so r_work still holds the
    // original operand here and its end bits give the final carry directly.
    always_comb begin
        w_earlyOut   = (r_type != SH_ROR) && (r_count >= 6'd32);
        w_earlyWork  = '0;
        w_earlyCarry = 1'b0;
        case (r_type)
            SH_LSL: begin
                if (r_count == 6'd32) begin
                    w_earlyCarry = r_work[0];
                end
            end
            SH_LSR: begin
                if (r_count == 6'd32) begin
                    w_earlyCarry = r_work[DATA_W-1];
                end
            end
            SH_ASR: begin
                w_earlyWork  = {DATA_W{r_work[DATA_W-1]}};
                w_earlyCarry = r_work[DATA_W-1];
            end
            default: begin
                w_earlyWork  = '0;
                w_earlyCarry = 1'b0;
            end
        endcase
    end

    // Pick the shortcut result when it applies, otherwise the normal step.
    always_comb begin
        w_shiftWork  = w_earlyOut ? w_earlyWork  : w_stepWork;
        w_shiftCarry = w_earlyOut ? w_earlyCarry : w_stepCarry;
        w_shiftDone  = w_earlyOut || (w_remainAfter == 6'd0);
    end
`else
    // Every count is worked off iteratively, STEP bits at a time.
    always_comb begin
        w_shiftWork  = w_stepWork;
        w_shiftCarry = w_stepCarry;
        w_shiftDone  = (w_remainAfter == 6'd0);
    end
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. A flush overrides everything and
    // sends the sequencer home; DONE always lasts exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        o_ready     = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (w_accept) begin
                    w_nextState = (w_effCount == 6'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_shiftDone) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            w_nextState = ST_IDLE;
        end
    end

    // Datapath. The working registers are loaded when a request is accepted
    // and stepped in SHIFT. The visible result registers are written only on
    // the edge that enters DONE, so a flushed operation leaves them untouched
    // and they hold across IDLE until the next completed shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_work     <= '0;
            r_carry    <= 1'b0;
            r_count    <= 6'd0;
            r_type     <= SH_LSL;
            r_valOut   <= '0;
            r_carryOut <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work  <= i_value;
                        r_carry <= i_carry_in;
                        r_count <= w_effCount;
                        r_type  <= i_shift_type;
                        if (w_effCount == 6'd0) begin
                            r_valOut   <= i_value;
                            r_carryOut <= i_carry_in;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!i_flush) begin
                        r_work  <= w_shiftWork;
                        r_carry <= w_shiftCarry;
                        r_count <= w_shiftDone ? 6'd0 : w_remainAfter;
                        if (w_shiftDone) begin
                            r_valOut   <= w_shiftWork;
                            r_carryOut <= w_shiftCarry;
                        end
                    end
                end
                default: begin
                    r_count <= 6'd0;
                end
            endcase
        end
    end

    assign o_val_out   = r_valOut;
    assign o_carry_out = r_carryOut;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for register-specified shifts (shift amount taken from Rs[7:0]) in the EX stage.
- The existing Val2 generator only handles 5-bit immediate shift amounts. This block produces the shifted operand and shifter carry-out iteratively, with ARM semantics for amounts 0..255.
- It stalls the pipeline through `busy` while it works.
- Single instance, owned by EX; the hazard unit consumes `busy`.

Parameters:
- STEP, 4, bits shifted per SHIFT cycle (legal values 1, 2, 4, 8).
- DATA_W, 32, operand width (only 32 is supported).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- value  input  32  Rm operand.
- amount  input  8  Rs[7:0].
- carry_in  input  1  current C flag.
- flush  input  1  synchronous abort.
- ready  output  1  high only in IDLE.
- busy  output  1  equals ~ready; stall request to the hazard unit.
- done  output  1  one-cycle pulse; val_out and carry_out are valid in that cycle.
- val_out  output  32  shifted result, registered.
- carry_out  output  1  shifter carry, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - ready=1, busy=0, done=0, val_out=0, carry_out=0, counter=0.
- States: IDLE, SHIFT, DONE.
- Effective count, latched at start:
  - LSL/LSR: min(amount, 33).
  - ASR: min(amount, 32).
  - ROR: 0 if amount==0; else 32 if amount[4:0]==0; else amount[4:0].
- IDLE:
  - start=1 & flush=0: latch value into the working register, carry_in into the carry register, and the count.
  - Next state is DONE if count==0, else SHIFT.
- SHIFT, each cycle:
  - Shift by n = min(STEP, remaining).
  - LSL/LSR shift in zeros; ASR shifts in value[31]; ROR rotates.
  - Carry register takes the last bit shifted out.
  - remaining -= n; when it reaches 0, go to DONE.
- Resulting semantics (checked by the bench):
  - LSL 32: result 0, C=value[0].
  - LSL/LSR >32: result 0, C=0.
  - LSR 32: result 0, C=value[31].
  - ASR >=32: result = 32 copies of value[31], C=value[31].
  - ROR with nonzero multiple of 32: result=value, C=value[31].
  - Amount 0, any type: result=value, C=carry_in.
- DONE: done=1 for exactly one cycle; val_out and carry_out are updated on entry; next state IDLE.
- Latency: start sampled at edge T; done high in cycle T+ceil(count/STEP)+1. Count 0 gives done at T+1.
- val_out and carry_out hold their value after done until the next DONE.
- start while busy is ignored; it is not queued.
- flush:
  - In any state, flush forces IDLE at the next edge.
  - No done pulse; val_out and carry_out are unchanged.
  - flush and start together in IDLE: flush wins, and the request is dropped.
- Reset asserted mid-operation: immediate return to reset values; no done.
- busy is high in SHIFT and DONE, so the stage holds until the done cycle. ready returns to 1 the cycle after done.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_OUT_EN.
- Defined: when count >= 32 for LSL/LSR/ASR, SHIFT lasts exactly one cycle. The final value and carry are loaded directly per the semantics above, giving latency T+2. ROR and counts <32 are unchanged.
- Undefined: all counts are processed iteratively, STEP bits per cycle.

Test Plan:
1. LSL, value=0x00000001, amount=4, carry_in=0 -> val_out=0x00000010, carry_out=0, done at T+2.
2. LSR, value=0x80000001, amount=1 -> val_out=0x40000000, carry_out=1, done at T+2.
3. ASR, value=0x80000000, amount=40 -> val_out=0xFFFFFFFF, carry_out=1.
   - Without macro: done at T+9.
   - With SHIFT_SEQ_EARLY_OUT_EN: done at T+2.
4. ROR, value=0x000000F1, amount=32 -> val_out=0x000000F1, carry_out=0.
   ROR, value=0x00000001, amount=4 -> val_out=0x10000000, carry_out=0.
5. LSL, value=0x00001234, amount=0, carry_in=1 -> val_out=0x00001234, carry_out=1, done at T+1, busy high for exactly 1 cycle.
6. Aborts and ignored start:
   - flush at T+3 of an LSL 33 -> ready=1 at T+4, no done, val_out unchanged.
   - rst low mid-SHIFT -> all outputs at reset values.
   - start during busy -> ignored.
